// File: rtl/cnn_sdiv_24s_12s_24_seq.sv
// ---------------------------------------------------------------------------
// cnn_sdiv_24s_12s_24_seq
//
// Sequential signed divider used for ECG layer requantisation: a 24-bit
// accumulated product is divided by a 12-bit signed layer scale. It is a
// radix-2 restoring divider that produces one quotient bit per enabled clock.
// The datapath works on unsigned magnitudes, and the signs are applied in a
// single fix-up cycle at the end.
//
// Ports
//   ap_clk       clock; all state changes on the rising edge
//   ap_rst_n     asynchronous active-low reset
//   ce           clock enable; when low, all state and outputs hold
//   start        request; sampled only while busy=0 and ce=1
//   din0         signed dividend, captured on the accepting edge
//   din1         signed divisor, captured on the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle pulse (held through ce=0) marking valid results
//   dout         signed quotient, truncated toward zero
//   rem          signed remainder, carrying the sign of the dividend
//   div_by_zero  set with done when the divisor was zero
//
// Timing: capture (1) + CALC (din0_WIDTH) + FIX (1) enabled edges, so done
// is high during the 26th enabled cycle after the accepting edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module cnn_sdiv_24s_12s_24_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 24,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero
);

    // ID is only an instance tag. Multiplying it by zero keeps it referenced
    // without changing the counter width.
    localparam int CNT_W  = $clog2(din0_WIDTH) + 0 * ID;
    localparam int PREM_W = din1_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(din0_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept;

    logic [CNT_W-1:0]      step;
    logic [din0_WIDTH-1:0] quo;
    logic [PREM_W-1:0]     prem;
    logic [din1_WIDTH-1:0] dmag;
    logic                  neg_a;
    logic                  neg_b;
    logic                  zero_div;

    logic [din0_WIDTH-1:0] amag_in;
    logic [din1_WIDTH-1:0] bmag_in;
    logic [PREM_W:0]       shifted;
    logic                  trial_ok;
    logic [din0_WIDTH-1:0] q_fix;
    logic [din1_WIDTH-1:0] r_fix;

    // Operand magnitudes at capture time. The most negative dividend maps to
    // 0x800000 and the divisor -2048 maps to 2048. Both still fit, because
    // the magnitudes are kept unsigned.
    always_comb begin
        amag_in = din0;
        bmag_in = din1;
        if (din0[din0_WIDTH-1]) begin
            amag_in = ~din0 + din0_WIDTH'(1);
        end
        if (din1[din1_WIDTH-1]) begin
            bmag_in = ~din1 + din1_WIDTH'(1);
        end
    end

    // One restoring step. The partial remainder is shifted left with the next
    // dividend bit (the MSB of quo) brought in. It is then compared against
    // the divisor magnitude. The extra top bit keeps 2*2047+1 representable,
    // so the comparison never wraps.
    always_comb begin
        shifted  = {prem, quo[din0_WIDTH-1]};
        trial_ok = (shifted >= {2'b00, dmag});
    end

    // Sign fix-up applied in the FIX cycle. The quotient is negated when the
    // operand signs differ. The remainder follows the sign of the dividend.
    always_comb begin
        q_fix = quo;
        r_fix = prem[din1_WIDTH-1:0];
        if (neg_a ^ neg_b) begin
            q_fix = ~quo + din0_WIDTH'(1);
        end
        if (neg_a) begin
            r_fix = ~prem[din1_WIDTH-1:0] + din1_WIDTH'(1);
        end
    end

    // State register. It advances only when the clock enable is high; that
    // gating is done in the next-state logic below.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. A request is taken only from IDLE, so
    // start while busy is simply ignored. busy drops as the FIX edge returns
    // to IDLE, which lets a start in the done cycle be accepted immediately.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (ce && start) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (ce && (step == LAST_STEP)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy = 1'b1;
                if (ce) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers.
    // - Capture latches the sign flags and the magnitudes, then clears the
    //   partial remainder and the step counter.
    // - Each CALC edge retires one quotient bit into the LSB of quo as the
    //   dividend bits shift out of its MSB.
    // - FIX publishes the signed results and raises done for one enabled
    //   cycle.
    // - A zero divisor overrides the results with the saturated quotient
    //   and a zero remainder. The overflow case -2^23 / -1 is left to wrap
    //   naturally.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            step        <= '0;
            quo         <= '0;
            prem        <= '0;
            dmag        <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            zero_div    <= 1'b0;
            done        <= 1'b0;
            dout        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        neg_a    <= din0[din0_WIDTH-1];
                        neg_b    <= din1[din1_WIDTH-1];
                        zero_div <= (din1 == '0);
                        quo      <= amag_in;
                        dmag     <= bmag_in;
                        prem     <= '0;
                        step     <= '0;
                    end
                end
                CALC: begin
                    step <= step + CNT_W'(1);
                    if (trial_ok) begin
                        prem <= PREM_W'(shifted - {2'b00, dmag});
                        quo  <= {quo[din0_WIDTH-2:0], 1'b1};
                    end else begin
                        prem <= PREM_W'(shifted);
                        quo  <= {quo[din0_WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= zero_div;
                    if (zero_div) begin
                        rem <= '0;
                        if (neg_a) begin
                            dout <= {1'b1, {(dout_WIDTH-1){1'b0}}};
                        end else begin
                            dout <= {1'b0, {(dout_WIDTH-1){1'b1}}};
                        end
                    end else begin
                        dout <= dout_WIDTH'(q_fix);
                        rem  <= r_fix;
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_sdiv_24s_12s_24_seq.sv
`timescale 1ns/1ps

module tb_cnn_sdiv_24s_12s_24_seq;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic        ce       = 1'b0;
    logic        start    = 1'b0;
    logic [23:0] din0     = '0;
    logic [11:0] din1     = '0;
    logic        busy;
    logic        done;
    logic [23:0] dout;
    logic [11:0] rem;
    logic        div_by_zero;

    int n_checks  = 0;
    int n_fail    = 0;
    int cycle_no  = 0;
    int start_cyc = 0;

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dz   = 1'b0;
    logic [23:0] m_q    = '0;
    logic [11:0] m_r    = '0;
    logic [36:0] m_pend = '0;
    int          m_left = 0;

    cnn_sdiv_24s_12s_24_seq #(
        .ID         (1),
        .din0_WIDTH (24),
        .din1_WIDTH (12),
        .dout_WIDTH (24)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ce          (ce),
        .start       (start),
        .din0        (din0),
        .din1        (din1),
        .busy        (busy),
        .done        (done),
        .dout        (dout),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    // Free-running 100 MHz clock
    always #5 ap_clk = ~ap_clk;

    // Rising-edge counter used to measure latency
    always @(posedge ap_clk) begin
        cycle_no = cycle_no + 1;
    end

    // Reference result from plain integer division, packed as {dz, rem, quo}.
    // SystemVerilog / and % truncate toward zero, and the remainder takes the
    // sign of the dividend. A zero divisor saturates by the sign of the
    // dividend.
    function automatic logic [36:0] reference(input logic [23:0] a, input logic [11:0] b);
        int          ia;
        int          ib;
        int          q;
        int          r;
        logic [23:0] qv;
        logic [11:0] rv;
        logic        dz;
        ia = $signed(a);
        ib = $signed(b);
        if (ib == 0) begin
            dz = 1'b1;
            rv = '0;
            qv = (ia < 0) ? 24'h800000 : 24'h7FFFFF;
        end else begin
            dz = 1'b0;
            q  = ia / ib;
            r  = ia % ib;
            qv = q[23:0];
            rv = r[11:0];
        end
        return {dz, rv, qv};
    endfunction

    // Transaction-level model: a request is taken when idle with ce high.
    // The result appears 25 enabled edges later as a done pulse that lasts
    // one enabled cycle. Results hold until the next completion or reset.
    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dz   <= 1'b0;
            m_left <= 0;
        end else if (ce) begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_dz, m_r, m_q} <= m_pend;
                end
            end else if (start) begin
                m_pend <= reference(din0, din1);
                m_busy <= 1'b1;
                m_left <= 25;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge ap_clk) begin
        checkOutput("busy", {31'b0, busy}, {31'b0, m_busy});
        checkOutput("done", {31'b0, done}, {31'b0, m_done});
        checkOutput("dout", {8'b0, dout}, {8'b0, m_q});
        checkOutput("rem", {20'b0, rem}, {20'b0, m_r});
        checkOutput("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dz});
    end

    // Pulse start for one cycle with the given operands, then scramble the
    // operand inputs, since the design must not depend on them afterwards.
    task automatic applyStimulus(input int a, input int b);
        @(negedge ap_clk);
        ce        = 1'b1;
        din0      = a[23:0];
        din1      = b[11:0];
        start     = 1'b1;
        start_cyc = cycle_no;
        @(negedge ap_clk);
        start = 1'b0;
        din0  = 24'($urandom());
        din1  = 12'($urandom());
    endtask

    task automatic waitDone(input string tag, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge ap_clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: done not seen, required within 80 cycles", tag);
        end
    endtask

    task automatic checkResult(input string tag, input int q, input int r, input logic dz);
        logic [23:0] eq;
        logic [11:0] er;
        eq = q[23:0];
        er = r[11:0];
        checkOutput({tag, "_dout"}, {8'b0, dout}, {8'b0, eq});
        checkOutput({tag, "_rem"}, {20'b0, rem}, {20'b0, er});
        checkOutput({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, dz});
        checkOutput({tag, "_latency"}, cycle_no - start_cyc, 26);
    endtask

    task automatic expectResult(input string tag, input int q, input int r, input logic dz);
        bit seen;
        waitDone(tag, seen);
        if (seen) checkResult(tag, q, r, dz);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        bit got;
        int nce;

        $display("[TB] starting cnn_sdiv_24s_12s_24_seq bench");
        #1 ap_rst_n = 1'b0;
        ce = 1'b1;
        repeat (3) @(negedge ap_clk);
        checkOutput("reset_dout", {8'b0, dout}, 32'h0);
        checkOutput("reset_rem", {20'b0, rem}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);
        ap_rst_n = 1'b1;

        // Directed divisions with hand-computed results
        applyStimulus(1000000, -37);
        expectResult("t_1e6_m37", -27027, 1, 1'b0);
        applyStimulus(-7, 2);
        expectResult("t_m7_2", -3, -1, 1'b0);
        applyStimulus(7, -2);
        expectResult("t_7_m2", -3, 1, 1'b0);
        applyStimulus(-8388608, -1);
        expectResult("t_overflow", -8388608, 0, 1'b0);
        applyStimulus(5, 0);
        expectResult("t_dz_pos", 8388607, 0, 1'b1);
        applyStimulus(-5, 0);
        expectResult("t_dz_neg", -8388608, 0, 1'b1);

        // Back-to-back requests with start held high throughout
        @(negedge ap_clk);
        din0      = 24'd100;
        din1      = 12'd7;
        start     = 1'b1;
        start_cyc = cycle_no;
        waitDone("b2b_first", seen);
        if (seen) begin
            checkResult("b2b_first", 14, 2, 1'b0);
            din0      = 24'd8388607;
            din1      = 12'h800;
            start_cyc = cycle_no;
            waitDone("b2b_second", seen);
            if (seen) checkResult("b2b_second", -4095, 2047, 1'b0);
        end
        start = 1'b0;

        // Clock enable toggling every cycle; done must hold while ce is low
        @(negedge ap_clk);
        din0  = 24'd100;
        din1  = 12'd7;
        start = 1'b1;
        ce    = 1'b1;
        nce   = 0;
        got   = 1'b0;
        for (int i = 0; i < 120 && !got; i++) begin
            if (ce) nce++;
            @(negedge ap_clk);
            start = 1'b0;
            if (done === 1'b1) got = 1'b1;
            else ce = ~ce;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ce_timeout: done not seen, required within 120 cycles");
        end else begin
            checkOutput("ce_enabled_cycles", nce, 26);
            checkOutput("ce_dout", {8'b0, dout}, 32'd14);
            checkOutput("ce_rem", {20'b0, rem}, 32'd2);
            ce = 1'b0;
            @(negedge ap_clk);
            checkOutput("ce_done_hold", {31'b0, done}, 32'h1);
            ce = 1'b1;
            @(negedge ap_clk);
            checkOutput("ce_done_fall", {31'b0, done}, 32'h0);
        end

        // Asynchronous reset in the middle of a division
        applyStimulus(12345, 67);
        repeat (9) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        checkOutput("arst_dout", {8'b0, dout}, 32'h0);
        checkOutput("arst_rem", {20'b0, rem}, 32'h0);
        checkOutput("arst_busy", {31'b0, busy}, 32'h0);
        checkOutput("arst_dz", {31'b0, div_by_zero}, 32'h0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (30) @(negedge ap_clk);
        applyStimulus(-1000000, 37);
        expectResult("t_after_reset", -27027, -1, 1'b0);

        // Randomised traffic with random ce and random start requests
        for (int i = 0; i < 2500; i++) begin
            @(negedge ap_clk);
            ce    = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 5))
                0:       din0 = 24'h800000;
                1:       din0 = 24'h7FFFFF;
                2:       din0 = 24'($urandom_range(0, 40)) - 24'd20;
                default: din0 = 24'($urandom());
            endcase
            case ($urandom_range(0, 7))
                0:       din1 = 12'h000;
                1:       din1 = 12'hFFF;
                2:       din1 = 12'h800;
                3:       din1 = 12'h7FF;
                4:       din1 = 12'($urandom_range(0, 16)) - 12'd8;
                default: din1 = 12'($urandom());
            endcase
        end
        start = 1'b0;
        ce    = 1'b1;
        repeat (30) @(negedge ap_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
